// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants, FSM state encoding and flag bit indices for alu_mc
package alu_pkg;

    localparam int OP_NOP   = 0;
    localparam int OP_ADD   = 1;
    localparam int OP_SUB   = 2;
    localparam int OP_BIMM  = 3;   // b + imm
    localparam int OP_AIMM  = 4;   // a + imm
    localparam int OP_MOVE  = 5;
    localparam int OP_SGE   = 6;
    localparam int OP_SLE   = 7;
    localparam int OP_SGT   = 8;
    localparam int OP_SLT   = 9;
    localparam int OP_SEQ   = 10;
    localparam int OP_SNE   = 11;
    localparam int OP_AND   = 12;
    localparam int OP_OR    = 13;
    localparam int OP_XOR   = 14;
    localparam int OP_NOT   = 15;
    localparam int OP_MOVEI = 16;
    localparam int OP_SLI   = 17;
    localparam int OP_SRI   = 18;
    localparam int OP_ADDI  = 19;
    localparam int OP_SUBI  = 20;
    localparam int OP_MUL   = 25;
    localparam int OP_DIV   = 26;
    localparam int OP_REM   = 27;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // flags = {illegal, div_by_zero, overflow, carry, zero}
    localparam int FLG_ZERO  = 0;
    localparam int FLG_CARRY = 1;
    localparam int FLG_OVF   = 2;
    localparam int FLG_DBZ   = 3;
    localparam int FLG_ILL   = 4;
    localparam int FLG_W     = 5;

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - WIDTH-step unsigned shift-add multiplier / restoring divider
// Ports: clk, reset (sync, active-high); start pulse loads a, b and op (1 = MUL, 0 = DIV);
// done is high during the final step, with lo/hi showing that step's outcome
// (MUL: {hi,lo} = a*b; DIV: lo = quotient, hi = remainder); dbz = divisor was zero.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             dbz
);

    localparam int CW = $clog2(WIDTH);

    logic             busy_q, busy_d;
    logic             mul_q, mul_d;
    logic             dbz_q, dbz_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand for MUL, divisor for DIV

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic             last;

    always_comb begin
        // MUL: lo holds the multiplier, consumed LSB first while the product shifts in from hi.
        sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        // DIV: dividend bits leave lo from the MSB, quotient bits enter at the LSB.
        trial = {hi_q, lo_q[WIDTH-1]};
        diff  = trial - {1'b0, opnd_q};
        ge    = (trial >= {1'b0, opnd_q});
        if (mul_q) begin
            step_hi = sum[WIDTH:1];
            step_lo = {sum[0], lo_q[WIDTH-1:1]};
        end else begin
            step_hi = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], ge};
        end
        last = busy_q && (cnt_q == CW'(WIDTH - 1));

        busy_d = busy_q;
        mul_d  = mul_q;
        dbz_d  = dbz_q;
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        opnd_d = opnd_q;
        if (start) begin
            busy_d = 1'b1;
            mul_d  = op;
            dbz_d  = !op && (b == '0);
            cnt_d  = '0;
            hi_d   = '0;
            lo_d   = op ? b : a;
            opnd_d = op ? a : b;
        end else if (busy_q) begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            mul_q  <= 1'b0;
            dbz_q  <= 1'b0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
        end else begin
            busy_q <= busy_d;
            mul_q  <= mul_d;
            dbz_q  <= dbz_d;
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
        end
    end

    assign done = last;
    assign lo   = step_lo;
    assign hi   = step_hi;
    assign dbz  = dbz_q;

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with valid/ready request and response handshakes
// Ports: clk, reset (sync, active-high); a, b, imm, opc request with in_valid/in_ready;
// result, result_hi, flags {illegal, div_by_zero, overflow, carry, zero} with out_valid/out_ready.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPC_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] imm,
    input  logic [OPC_W-1:0] opc,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [FLG_W-1:0] flags
);

    localparam int SW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic [FLG_W-1:0] flags_q, flags_d;
    logic [OPC_W-1:0] opc_q, opc_d;

    // single-cycle datapath, evaluated on the live request inputs
    logic [WIDTH-1:0] sc_res;
    logic [FLG_W-1:0] sc_flags;
    logic             is_long;
    logic             illegal;
    logic             use_add;
    logic             add_sub;
    logic [WIDTH-1:0] add_x, add_y, add_ye;
    logic [WIDTH:0]   add_sum;

    logic             it_start, it_done, it_dbz;
    logic [WIDTH-1:0] it_lo, it_hi;
    logic [WIDTH-1:0] lng_res, lng_hi;
    logic [FLG_W-1:0] lng_flags;

    always_comb begin
        sc_res  = '0;
        is_long = 1'b0;
        illegal = 1'b0;
        use_add = 1'b0;
        add_sub = 1'b0;
        add_x   = a;
        add_y   = b;
        case (opc)
            OPC_W'(OP_NOP), OPC_W'(OP_MOVE): sc_res = a;
            OPC_W'(OP_ADD):  use_add = 1'b1;
            OPC_W'(OP_SUB):  begin use_add = 1'b1; add_sub = 1'b1; end
            OPC_W'(OP_BIMM): begin use_add = 1'b1; add_x = b; add_y = imm; end
            OPC_W'(OP_AIMM), OPC_W'(OP_ADDI): begin use_add = 1'b1; add_y = imm; end
            OPC_W'(OP_SUBI): begin use_add = 1'b1; add_y = imm; add_sub = 1'b1; end
            OPC_W'(OP_SGE):  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) >= $signed(b))};
            OPC_W'(OP_SLE):  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) <= $signed(b))};
            OPC_W'(OP_SGT):  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) >  $signed(b))};
            OPC_W'(OP_SLT):  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) <  $signed(b))};
            OPC_W'(OP_SEQ):  sc_res = {{(WIDTH-1){1'b0}}, (a == b)};
            OPC_W'(OP_SNE):  sc_res = {{(WIDTH-1){1'b0}}, (a != b)};
            OPC_W'(OP_AND):  sc_res = a & b;
            OPC_W'(OP_OR):   sc_res = a | b;
            OPC_W'(OP_XOR):  sc_res = a ^ b;
            OPC_W'(OP_NOT):  sc_res = ~a;
            OPC_W'(OP_MOVEI): sc_res = imm;
            OPC_W'(OP_SLI):  sc_res = (imm >= WIDTH'(WIDTH)) ? '0 : (a << imm[SW-1:0]);
            OPC_W'(OP_SRI):  sc_res = (imm >= WIDTH'(WIDTH)) ? '0 : (a >> imm[SW-1:0]);
            OPC_W'(OP_MUL), OPC_W'(OP_DIV), OPC_W'(OP_REM): is_long = 1'b1;
            default:         illegal = 1'b1;
        endcase

        // subtraction as x + ~y + 1, so carry-out is directly NOT borrow
        add_ye  = add_sub ? ~add_y : add_y;
        add_sum = {1'b0, add_x} + {1'b0, add_ye} + {{WIDTH{1'b0}}, add_sub};
        sc_flags = '0;
        if (use_add) begin
            sc_res             = add_sum[WIDTH-1:0];
            sc_flags[FLG_CARRY] = add_sum[WIDTH];
            sc_flags[FLG_OVF]   = (add_x[WIDTH-1] == add_ye[WIDTH-1]) &&
                                  (add_sum[WIDTH-1] != add_x[WIDTH-1]);
        end
        sc_flags[FLG_ILL]  = illegal;
        sc_flags[FLG_ZERO] = !illegal && (sc_res == '0);
    end

    // REM reports the same divider outputs with the halves swapped
    always_comb begin
        lng_res = (opc_q == OPC_W'(OP_REM)) ? it_hi : it_lo;
        lng_hi  = (opc_q == OPC_W'(OP_REM)) ? it_lo : it_hi;
        lng_flags = '0;
        lng_flags[FLG_ZERO] = (lng_res == '0);
        lng_flags[FLG_OVF]  = (opc_q == OPC_W'(OP_MUL)) && (it_hi != '0);
        lng_flags[FLG_DBZ]  = (opc_q != OPC_W'(OP_MUL)) && it_dbz;
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        flags_d     = flags_q;
        opc_d       = opc_q;
        it_start    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    opc_d = opc;
                    if (is_long) begin
                        it_start = 1'b1;
                        state_d  = ST_BUSY;
                    end else begin
                        result_d    = sc_res;
                        result_hi_d = '0;
                        flags_d     = sc_flags;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_BUSY: begin
                if (it_done) begin
                    result_d    = lng_res;
                    result_hi_d = lng_hi;
                    flags_d     = lng_flags;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
            opc_q       <= '0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            flags_q     <= flags_d;
            opc_q       <= opc_d;
        end
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk   (clk),
        .reset (reset),
        .start (it_start),
        .op    (opc == OPC_W'(OP_MUL)),
        .a     (a),
        .b     (b),
        .done  (it_done),
        .lo    (it_lo),
        .hi    (it_hi),
        .dbz   (it_dbz)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - directed self-checking bench for alu_mc at WIDTH=32
module tb_alu_mc;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] a = '0, b = '0, imm = '0;
    logic [5:0]  opc = '0;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [31:0] result, result_hi;
    logic [4:0]  flags;

    int n_cmp = 0;
    int n_bad = 0;
    int lat;
    logic [31:0] r, h;
    logic [4:0]  f;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32), .OPC_W(6)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .imm(imm), .opc(opc),
        .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .result_hi(result_hi), .flags(flags)
    );

    // Issue one request, measure latency in edges (accept edge counts as 1), capture and consume.
    task automatic run_op(input int op, input logic [31:0] ia, ib, iimm,
                          output int olat, output logic [31:0] orr, ohh, output logic [4:0] off);
        int w;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: in_ready=%b want 1", in_ready);
        end
        a = ia; b = ib; imm = iimm; opc = op[5:0]; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~ia; b = ~ib; imm = ~iimm;    // operands must already be captured
        olat = 1;
        while (!out_valid && olat < 100) begin @(posedge clk); #1; olat++; end
        orr = result; ohh = result_hi; off = flags;
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++;
            $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (result !== 32'h0 || result_hi !== 32'h0 || flags !== 5'b0) begin n_bad++;
            $display("FAIL reset_out: r=%h h=%h f=%b want 0/0/00000", result, result_hi, flags); end
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    endtask

    task automatic test_add_sub;
        run_op(OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, lat, r, h, f);
        n_cmp++; if (r !== 32'h0 || h !== 32'h0 || f !== 5'b00011 || lat != 1) begin n_bad++;
            $display("FAIL add_wrap: r=%h h=%h f=%b lat=%0d want 0/0/00011/1", r, h, f, lat); end
        run_op(OP_SUB, 32'h5, 32'h7, 32'h0, lat, r, h, f);
        n_cmp++; if (r !== 32'hFFFF_FFFE || f !== 5'b00000 || lat != 1) begin n_bad++;
            $display("FAIL sub_borrow: r=%h f=%b lat=%0d want fffffffe/00000/1", r, f, lat); end
        run_op(OP_SUB, 32'h8000_0000, 32'h1, 32'h0, lat, r, h, f);
        n_cmp++; if (r !== 32'h7FFF_FFFF || f !== 5'b00110) begin n_bad++;
            $display("FAIL sub_ovf: r=%h f=%b want 7fffffff/00110", r, f); end
        run_op(OP_BIMM, 32'd999, 32'd10, 32'd20, lat, r, h, f);
        n_cmp++; if (r !== 32'd30 || f !== 5'b00000) begin n_bad++;
            $display("FAIL b_imm: r=%h f=%b want 0000001e/00000", r, f); end
        run_op(OP_AIMM, 32'hFFFF_FFF0, 32'd5, 32'h10, lat, r, h, f);
        n_cmp++; if (r !== 32'h0 || f !== 5'b00011) begin n_bad++;
            $display("FAIL a_imm: r=%h f=%b want 0/00011", r, f); end
        run_op(OP_ADDI, 32'h7FFF_FFFF, 32'd0, 32'h1, lat, r, h, f);
        n_cmp++; if (r !== 32'h8000_0000 || f !== 5'b00100) begin n_bad++;
            $display("FAIL addi_ovf: r=%h f=%b want 80000000/00100", r, f); end
        run_op(OP_SUBI, 32'd3, 32'd9, 32'd3, lat, r, h, f);
        n_cmp++; if (r !== 32'h0 || f !== 5'b00011) begin n_bad++;
            $display("FAIL subi_zero: r=%h f=%b want 0/00011", r, f); end
    endtask

    task automatic test_logic_move;
        run_op(OP_AND, 32'hF0F0, 32'hFF00, 32'h0, lat, r, h, f);
        n_cmp++; if (r !== 32'hF000 || f !== 5'b0) begin n_bad++; $display("FAIL and: r=%h f=%b want 0000f000/00000", r, f); end
        run_op(OP_OR, 32'hF0F0, 32'h0F0F, 32'h0, lat, r, h, f);
        n_cmp++; if (r !== 32'hFFFF) begin n_bad++; $display("FAIL or: r=%h want 0000ffff", r); end
        run_op(OP_XOR, 32'h00FF, 32'h0F0F, 32'h0, lat, r, h, f);
        n_cmp++; if (r !== 32'h0FF0) begin n_bad++; $display("FAIL xor: r=%h want 00000ff0", r); end
        run_op(OP_NOT, 32'h0, 32'h1, 32'h0, lat, r, h, f);
        n_cmp++; if (r !== 32'hFFFF_FFFF || f !== 5'b0) begin n_bad++; $display("FAIL not: r=%h f=%b want ffffffff/00000", r, f); end
        run_op(OP_MOVEI, 32'h55, 32'h66, 32'h1234, lat, r, h, f);
        n_cmp++; if (r !== 32'h1234 || h !== 32'h0) begin n_bad++; $display("FAIL movei: r=%h h=%h want 00001234/0", r, h); end
        run_op(OP_MOVE, 32'hABCD, 32'h1, 32'h2, lat, r, h, f);
        n_cmp++; if (r !== 32'hABCD) begin n_bad++; $display("FAIL move: r=%h want 0000abcd", r); end
        run_op(OP_NOP, 32'h0, 32'h7, 32'h7, lat, r, h, f);
        n_cmp++; if (r !== 32'h0 || f !== 5'b00001 || lat != 1) begin n_bad++; $display("FAIL nop: r=%h f=%b lat=%0d want 0/00001/1", r, f, lat); end
    endtask

    task automatic test_compare;
        run_op(OP_SGE, 32'hFFFF_FFFF, 32'h0, 32'h0, lat, r, h, f);
        n_cmp++; if (r !== 32'h0 || f !== 5'b00001) begin n_bad++; $display("FAIL sge_neg: r=%h f=%b want 0/00001", r, f); end
        run_op(OP_SGE, 32'd3, 32'd3, 32'h0, lat, r, h, f);
        n_cmp++; if (r !== 32'h1) begin n_bad++; $display("FAIL sge_eq: r=%h want 1", r); end
        run_op(OP_SLE, 32'hFFFF_FFFF, 32'h0, 32'h0, lat, r, h, f);
        n_cmp++; if (r !== 32'h1) begin n_bad++; $display("FAIL sle: r=%h want 1", r); end
        run_op(OP_SGT, 32'd5, 32'hFFFF_FFFD, 32'h0, lat, r, h, f);
        n_cmp++; if (r !== 32'h1 || f !== 5'b0) begin n_bad++; $display("FAIL sgt: r=%h f=%b want 1/00000", r, f); end
        run_op(OP_SEQ, 32'd7, 32'd7, 32'h0, lat, r, h, f);
        n_cmp++; if (r !== 32'h1) begin n_bad++; $display("FAIL seq: r=%h want 1", r); end
        run_op(OP_SNE, 32'd7, 32'd7, 32'h0, lat, r, h, f);
        n_cmp++; if (r !== 32'h0 || f !== 5'b00001) begin n_bad++; $display("FAIL sne: r=%h f=%b want 0/00001", r, f); end
    endtask

    task automatic test_shift;
        run_op(OP_SLI, 32'h1, 32'h0, 32'd4, lat, r, h, f);
        n_cmp++; if (r !== 32'h10) begin n_bad++; $display("FAIL sli4: r=%h want 00000010", r); end
        run_op(OP_SLI, 32'h1, 32'h0, 32'd31, lat, r, h, f);
        n_cmp++; if (r !== 32'h8000_0000) begin n_bad++; $display("FAIL sli31: r=%h want 80000000", r); end
        run_op(OP_SRI, 32'h8000_0000, 32'h0, 32'd31, lat, r, h, f);
        n_cmp++; if (r !== 32'h1) begin n_bad++; $display("FAIL sri31: r=%h want 1", r); end
        run_op(OP_SLI, 32'h1, 32'h0, 32'd32, lat, r, h, f);
        n_cmp++; if (r !== 32'h0 || f !== 5'b00001) begin n_bad++; $display("FAIL sli32: r=%h f=%b want 0/00001", r, f); end
        run_op(OP_SRI, 32'hFFFF_FFFF, 32'h0, 32'd100, lat, r, h, f);
        n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL sri100: r=%h want 0", r); end
    endtask

    task automatic test_mul;
        run_op(OP_MUL, 32'h1_0000, 32'h1_0000, 32'h0, lat, r, h, f);
        n_cmp++; if (r !== 32'h0 || h !== 32'h1 || f !== 5'b00101 || lat != 33) begin n_bad++;
            $display("FAIL mul_2p32: r=%h h=%h f=%b lat=%0d want 0/1/00101/33", r, h, f, lat); end
        run_op(OP_MUL, 32'd7, 32'd6, 32'h0, lat, r, h, f);
        n_cmp++; if (r !== 32'd42 || h !== 32'h0 || f !== 5'b0 || lat != 33) begin n_bad++;
            $display("FAIL mul_small: r=%h h=%h f=%b lat=%0d want 2a/0/00000/33", r, h, f, lat); end
        run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, lat, r, h, f);
        n_cmp++; if (r !== 32'h1 || h !== 32'hFFFF_FFFE || f !== 5'b00100) begin n_bad++;
            $display("FAIL mul_max: r=%h h=%h f=%b want 1/fffffffe/00100", r, h, f); end
    endtask

    task automatic test_div;
        run_op(OP_DIV, 32'd100, 32'd0, 32'h0, lat, r, h, f);
        n_cmp++; if (r !== 32'hFFFF_FFFF || h !== 32'd100 || f !== 5'b01000 || lat != 33) begin n_bad++;
            $display("FAIL div_by0: r=%h h=%h f=%b lat=%0d want ffffffff/64/01000/33", r, h, f, lat); end
        run_op(OP_DIV, 32'd100, 32'd7, 32'h0, lat, r, h, f);
        n_cmp++; if (r !== 32'd14 || h !== 32'd2 || f !== 5'b0 || lat != 33) begin n_bad++;
            $display("FAIL div_100_7: r=%h h=%h f=%b lat=%0d want e/2/00000/33", r, h, f, lat); end
        run_op(OP_REM, 32'd100, 32'd7, 32'h0, lat, r, h, f);
        n_cmp++; if (r !== 32'd2 || h !== 32'd14 || f !== 5'b0) begin n_bad++;
            $display("FAIL rem_100_7: r=%h h=%h f=%b want 2/e/00000", r, h, f); end
        run_op(OP_DIV, 32'd6, 32'd7, 32'h0, lat, r, h, f);
        n_cmp++; if (r !== 32'd0 || h !== 32'd6 || f !== 5'b00001) begin n_bad++;
            $display("FAIL div_small: r=%h h=%h f=%b want 0/6/00001", r, h, f); end
        run_op(OP_REM, 32'd100, 32'd0, 32'h0, lat, r, h, f);
        n_cmp++; if (r !== 32'd100 || h !== 32'hFFFF_FFFF || f !== 5'b01000) begin n_bad++;
            $display("FAIL rem_by0: r=%h h=%h f=%b want 64/ffffffff/01000", r, h, f); end
    endtask

    task automatic test_illegal;
        run_op(40, 32'd5, 32'd5, 32'd5, lat, r, h, f);
        n_cmp++; if (r !== 32'h0 || h !== 32'h0 || f !== 5'b10000 || lat != 1) begin n_bad++;
            $display("FAIL illegal_40: r=%h h=%h f=%b lat=%0d want 0/0/10000/1", r, h, f, lat); end
        run_op(21, 32'd9, 32'd1, 32'd1, lat, r, h, f);
        n_cmp++; if (r !== 32'h0 || f !== 5'b10000) begin n_bad++;
            $display("FAIL illegal_21: r=%h f=%b want 0/10000", r, f); end
    endtask

    task automatic test_backpressure;
        int bad;
        @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'h0; imm = 32'h0; opc = 6'(OP_SLT); in_valid = 1'b1;
        @(posedge clk); #1;
        // keep offering a different request; it must be ignored while DONE
        a = 32'd5; b = 32'd5; opc = 6'(OP_ADD);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || result !== 32'h1 || flags !== 5'b0 || in_ready !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        n_cmp++; if (bad != 0) begin n_bad++;
            $display("FAIL backpressure_hold: %0d bad cycles, last r=%h f=%b in_ready=%b want 1/00000/0", bad, result, flags, in_ready); end
        in_valid = 1'b0;
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_back_to_back;
        run_op(OP_MOVEI, 32'h0, 32'h0, 32'h77, lat, r, h, f);
        @(negedge clk);
        a = 32'd1; b = 32'd1; imm = 32'h99; opc = 6'(OP_MOVEI); in_valid = 1'b1;
        @(posedge clk); #1;   // accepted, now DONE
        a = 32'd2; b = 32'd2; opc = 6'(OP_ADD);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;   // consume edge: the ADD must not be taken here
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h99) begin n_bad++;
            $display("FAIL b2b_consume: out_valid=%b in_ready=%b r=%h want 0/1/99", out_valid, in_ready, result); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || result !== 32'd4) begin n_bad++;
            $display("FAIL b2b_next: out_valid=%b r=%h want 1/4", out_valid, result); end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_div;
        int seen;
        @(negedge clk);
        a = 32'd100; b = 32'd7; opc = 6'(OP_DIV); in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (4) @(posedge clk);       // now in the 5th BUSY cycle
        @(negedge clk); reset = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0 || result !== 32'h0 || result_hi !== 32'h0 || flags !== 5'b0) begin n_bad++;
            $display("FAIL midreset_clear: out_valid=%b r=%h h=%h f=%b want 0/0/0/00000", out_valid, result, result_hi, flags); end
        @(negedge clk); reset = 1'b0; out_ready = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++;
            $display("FAIL midreset_ready: in_ready=%b want 1", in_ready); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen++;
        end
        n_cmp++; if (seen != 0) begin n_bad++;
            $display("FAIL midreset_noresp: out_valid high %0d cycles want 0", seen); end
        run_op(OP_ADD, 32'd2, 32'd3, 32'h0, lat, r, h, f);
        n_cmp++; if (r !== 32'd5 || h !== 32'h0 || f !== 5'b0 || lat != 1) begin n_bad++;
            $display("FAIL midreset_add: r=%h h=%h f=%b lat=%0d want 5/0/00000/1", r, h, f, lat); end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_logic_move();
        test_compare();
        test_shift();
        test_mul();
        test_div();
        test_illegal();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
